// File: rtl/ctrl_fsm_p.sv
// ctrl_fsm_p: multi-cycle instruction sequencer (FETCH/FWAIT/DECODE/EX1..EX3) driving datapath strobes.
//
// Ports:
//   clock      rising-edge clock
//   resetn     synchronous active-low reset (state -> FETCH, all outputs forced to 0)
//   run        advance enable; when low the state holds and every output is 0
//   ir         instruction register contents {op[3:0], imm, rx, ..., ry}
//   btrue      branch condition from datapath
//   mem_ready  memory access complete (only honoured when CTRL_MEM_WAIT_EN is defined)
//   ir_in, a_in, g_in, addr_in, dout_in, wren, pc_inc, pc_in, mvt, done   datapath strobes
//   r_in       one-hot register write enables (register NREG-1 is the PC and uses pc_in instead)
//   select     bus mux: 0..NREG-1 register, NREG = G, NREG+1 = immediate, NREG+2 = memory data
//   alu_op     0 add, 1 sub, 2 and, 3 sll, 4 srl
//   bope       0 b, 1 beq, 2 bne
//
// Build option: define CTRL_MEM_WAIT_EN to make fetch, ld and st wait for mem_ready;
// otherwise every memory access is assumed to complete in one cycle.
module ctrl_fsm_p #(
    parameter int NREG = 8,
    parameter int IRW = 16,
    localparam int RXW = $clog2(NREG),
    localparam int SELW = $clog2(NREG + 3)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            run,
    input  logic [IRW-1:0]  ir,
    input  logic            btrue,
    input  logic            mem_ready,
    output logic            ir_in,
    output logic            a_in,
    output logic            g_in,
    output logic            addr_in,
    output logic            dout_in,
    output logic            wren,
    output logic            pc_inc,
    output logic            pc_in,
    output logic            mvt,
    output logic            done,
    output logic [NREG-1:0] r_in,
    output logic [SELW-1:0] select,
    output logic [2:0]      alu_op,
    output logic [1:0]      bope
);
    typedef enum logic [2:0] {FETCH, FWAIT, DECODE, EX1, EX2, EX3} state_t;
    localparam logic [SELW-1:0] SEL_PC  = SELW'(NREG - 1);
    localparam logic [SELW-1:0] SEL_G   = SELW'(NREG);
    localparam logic [SELW-1:0] SEL_IMM = SELW'(NREG + 1);
    localparam logic [SELW-1:0] SEL_MEM = SELW'(NREG + 2);
    state_t state_q, state_d;
    logic [3:0]     op;
    logic           imm;
    logic [RXW-1:0] rx, ry;
    logic           is_alu, is_br, wr, mem_ok, unused_ir;
    logic [2:0]     alu_code;
    assign op        = ir[IRW-1 -: 4];
    assign imm       = ir[IRW-5];
    assign rx        = ir[IRW-6 -: RXW];
    assign ry        = ir[RXW-1:0];
    assign unused_ir = ^ir;
    assign is_alu    = (op == 4'h2) || (op == 4'h3) || (op == 4'h4) || (op == 4'hA) || (op == 4'hB);
    assign is_br     = (op == 4'h7) || (op == 4'h8) || (op == 4'h9);
    assign alu_code  = (op == 4'h2) ? 3'd0 : (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 :
                       (op == 4'hA) ? 3'd3 : 3'd4;
`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif
    always_ff @(posedge clock) begin
        state_q <= !resetn ? FETCH : state_d;
    end
    // Outputs are gated by resetn as well as run so that the cycle in which reset is
    // applied already shows no strobes, and an abandoned instruction never writes.
    always_comb begin
        state_d = state_q;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addr_in = 1'b0;
        dout_in = 1'b0;
        wren    = 1'b0;
        pc_inc  = 1'b0;
        pc_in   = 1'b0;
        mvt     = 1'b0;
        done    = 1'b0;
        r_in    = '0;
        select  = '0;
        alu_op  = 3'd0;
        bope    = 2'd0;
        wr      = 1'b0;
        if (run && resetn) begin
            case (state_q)
                FETCH: begin
                    select  = SEL_PC;
                    addr_in = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = FWAIT;
                end
                FWAIT: state_d = mem_ok ? DECODE : FWAIT;
                DECODE: begin
                    ir_in   = 1'b1;
                    state_d = EX1;
                end
                EX1: begin
                    state_d = EX2;
                    if (op == 4'h0) begin
                        select = imm ? SEL_IMM : SELW'(ry);
                        wr     = 1'b1;
                        done   = 1'b1;
                    end else if (op == 4'h1) begin
                        select = SEL_IMM;
                        mvt    = 1'b1;
                        wr     = 1'b1;
                        done   = 1'b1;
                    end else if (is_alu) begin
                        select = SELW'(rx);
                        a_in   = 1'b1;
                    end else if (op == 4'h5 || op == 4'h6) begin
                        select  = SELW'(ry);
                        addr_in = 1'b1;
                    end else if (is_br) begin
                        bope = 2'(op - 4'h7);
                        // Taken branch: latch PC into A so EX2 can add the offset.
                        if (btrue) begin
                            select = SEL_PC;
                            a_in   = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
                    end else begin
                        done = 1'b1;
                    end
                end
                EX2: begin
                    if (is_alu) begin
                        select  = imm ? SEL_IMM : SELW'(ry);
                        alu_op  = alu_code;
                        g_in    = 1'b1;
                        state_d = EX3;
                    end else if (op == 4'h5) begin
                        state_d = mem_ok ? EX3 : EX2;
                    end else if (op == 4'h6) begin
                        select  = SELW'(rx);
                        dout_in = 1'b1;
                        wren    = 1'b1;
                        done    = mem_ok;
                    end else if (is_br) begin
                        select  = SEL_IMM;
                        g_in    = 1'b1;
                        state_d = EX3;
                    end else begin
                        state_d = FETCH;
                    end
                end
                EX3: begin
                    state_d = FETCH;
                    if (is_alu) begin
                        select = SEL_G;
                        wr     = 1'b1;
                        done   = 1'b1;
                    end else if (op == 4'h5) begin
                        select = SEL_MEM;
                        wr     = 1'b1;
                        done   = 1'b1;
                    end else if (is_br) begin
                        select = SEL_G;
                        pc_in  = 1'b1;
                        done   = 1'b1;
                    end
                end
                default: state_d = FETCH;
            endcase
            // Writing the top register means writing the PC, which has its own strobe.
            if (wr) begin
                if (rx == RXW'(NREG - 1)) pc_in = 1'b1;
                else r_in[rx] = 1'b1;
            end
            if (done) state_d = FETCH;
        end
    end
endmodule

// File: tb/tb_ctrl_fsm_p.sv
// tb_ctrl_fsm_p: scoreboard bench; stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_ctrl_fsm_p;
    logic        clock, resetn, run, btrue, mem_ready;
    logic [15:0] ir;
    logic        ir_in, a_in, g_in, addr_in, dout_in, wren, pc_inc, pc_in, mvt, done;
    logic [7:0]  r_in;
    logic [3:0]  select;
    logic [2:0]  alu_op;
    logic [1:0]  bope;

    localparam logic [9:0] IR_IN = 10'h200, A_IN = 10'h100, G_IN = 10'h080, ADDR_IN = 10'h040,
                           DOUT = 10'h020, WREN = 10'h010, PC_INC = 10'h008, PC_IN = 10'h004,
                           MVT = 10'h002, DONE = 10'h001;
    localparam logic [26:0] Z = 27'd0;
`ifdef CTRL_MEM_WAIT_EN
    localparam logic MR = 1'b1;
`else
    localparam logic MR = 1'b0;
`endif

    ctrl_fsm_p dut (
        .clock(clock), .resetn(resetn), .run(run), .ir(ir), .btrue(btrue), .mem_ready(mem_ready),
        .ir_in(ir_in), .a_in(a_in), .g_in(g_in), .addr_in(addr_in), .dout_in(dout_in),
        .wren(wren), .pc_inc(pc_inc), .pc_in(pc_in), .mvt(mvt), .done(done),
        .r_in(r_in), .select(select), .alu_op(alu_op), .bope(bope)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    string       names[$];
    logic [26:0] exps[$];
    int          checks = 0, errors = 0, pushed = 0;

    function automatic logic [26:0] ex(input logic [9:0] s, input logic [7:0] r,
                                       input logic [3:0] sel, input logic [2:0] op,
                                       input logic [1:0] bo);
        return {s, r, sel, op, bo};
    endfunction

    always @(negedge clock) begin
        if (exps.size() > 0) begin
            logic [26:0] act, e;
            string nm;
            act = {ir_in, a_in, g_in, addr_in, dout_in, wren, pc_inc, pc_in, mvt, done,
                   r_in, select, alu_op, bope};
            e = exps.pop_front();
            nm = names.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    task automatic step(input logic r, input logic rn, input logic mr, input string nm,
                        input logic [26:0] e);
        run = r;
        resetn = rn;
        mem_ready = mr;
        names.push_back(nm);
        exps.push_back(e);
        pushed++;
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [26:0] e);
        step(1'b1, 1'b1, MR, nm, e);
    endtask

    task automatic fetch(input logic [15:0] i, input string nm);
        ir = i;
        cyc({nm, "_fetch"}, ex(ADDR_IN | PC_INC, 8'h00, 4'd7, 3'd0, 2'd0));
        cyc({nm, "_fwait"}, Z);
        cyc({nm, "_decode"}, ex(IR_IN, 8'h00, 4'd0, 3'd0, 2'd0));
    endtask

    task automatic alu(input logic [15:0] i, input string nm, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [2:0] op, input logic [9:0] wst,
                       input logic [7:0] r);
        fetch(i, nm);
        cyc({nm, "_ex1"}, ex(A_IN, 8'h00, s1, 3'd0, 2'd0));
        cyc({nm, "_ex2"}, ex(G_IN, 8'h00, s2, op, 2'd0));
        cyc({nm, "_ex3"}, ex(DONE | wst, r, 4'd8, 3'd0, 2'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ir = 16'h0000;
        run = 1'b0;
        resetn = 1'b0;
        btrue = 1'b0;
        mem_ready = MR;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, MR, "rst_run_high", Z);
        step(1'b0, 1'b0, MR, "rst_run_low", Z);
        step(1'b0, 1'b1, MR, "idle_after_rst", Z);
        alu(16'h2102, "add", 4'd1, 4'd2, 3'd0, 10'h000, 8'h02);
        alu(16'h3B05, "sub_imm", 4'd3, 4'd9, 3'd1, 10'h000, 8'h08);
        alu(16'h4605, "and", 4'd6, 4'd5, 3'd2, 10'h000, 8'h40);
        alu(16'hA204, "sll", 4'd2, 4'd4, 3'd3, 10'h000, 8'h04);
        alu(16'hB701, "srl_pc", 4'd7, 4'd1, 3'd4, PC_IN, 8'h00);
        fetch(16'h0F05, "mv_imm_pc");
        cyc("mv_imm_pc_ex1", ex(DONE | PC_IN, 8'h00, 4'd9, 3'd0, 2'd0));
        fetch(16'h0306, "mv_reg");
        cyc("mv_reg_ex1", ex(DONE, 8'h08, 4'd6, 3'd0, 2'd0));
        fetch(16'h1A00, "mvt");
        cyc("mvt_ex1", ex(DONE | MVT, 8'h04, 4'd9, 3'd0, 2'd0));
        fetch(16'h8000, "beq_nt");
        cyc("beq_nt_ex1", ex(DONE, 8'h00, 4'd0, 3'd0, 2'd1));
        fetch(16'h7000, "b_nt");
        cyc("b_nt_ex1", ex(DONE, 8'h00, 4'd0, 3'd0, 2'd0));
        btrue = 1'b1;
        fetch(16'h8000, "beq_t");
        cyc("beq_t_ex1", ex(A_IN, 8'h00, 4'd7, 3'd0, 2'd1));
        cyc("beq_t_ex2", ex(G_IN, 8'h00, 4'd9, 3'd0, 2'd0));
        cyc("beq_t_ex3", ex(DONE | PC_IN, 8'h00, 4'd8, 3'd0, 2'd0));
        fetch(16'h9000, "bne_t");
        cyc("bne_t_ex1", ex(A_IN, 8'h00, 4'd7, 3'd0, 2'd2));
        cyc("bne_t_ex2", ex(G_IN, 8'h00, 4'd9, 3'd0, 2'd0));
        cyc("bne_t_ex3", ex(DONE | PC_IN, 8'h00, 4'd8, 3'd0, 2'd0));
        btrue = 1'b0;
        fetch(16'h5403, "ld");
        cyc("ld_ex1", ex(ADDR_IN, 8'h00, 4'd3, 3'd0, 2'd0));
        cyc("ld_ex2", Z);
        cyc("ld_ex3", ex(DONE, 8'h10, 4'd10, 3'd0, 2'd0));
        fetch(16'h6205, "st");
        cyc("st_ex1", ex(ADDR_IN, 8'h00, 4'd5, 3'd0, 2'd0));
`ifdef CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, "st_ex2_wait", ex(DOUT | WREN, 8'h00, 4'd2, 3'd0, 2'd0));
        step(1'b1, 1'b1, 1'b1, "st_ex2_done", ex(DOUT | WREN | DONE, 8'h00, 4'd2, 3'd0, 2'd0));
`else
        step(1'b1, 1'b1, 1'b0, "st_ex2_done", ex(DOUT | WREN | DONE, 8'h00, 4'd2, 3'd0, 2'd0));
`endif
        fetch(16'hF000, "nop");
        cyc("nop_ex1", ex(DONE, 8'h00, 4'd0, 3'd0, 2'd0));
        fetch(16'h2102, "add_hold");
        step(1'b0, 1'b1, MR, "add_hold_run0_a", Z);
        step(1'b0, 1'b1, MR, "add_hold_run0_b", Z);
        cyc("add_hold_ex1", ex(A_IN, 8'h00, 4'd1, 3'd0, 2'd0));
        cyc("add_hold_ex2", ex(G_IN, 8'h00, 4'd2, 3'd0, 2'd0));
        cyc("add_hold_ex3", ex(DONE, 8'h02, 4'd8, 3'd0, 2'd0));
        fetch(16'h5403, "ld_rst");
        cyc("ld_rst_ex1", ex(ADDR_IN, 8'h00, 4'd3, 3'd0, 2'd0));
        step(1'b1, 1'b0, MR, "ld_rst_ex2_reset", Z);
        step(1'b1, 1'b0, MR, "ld_rst_hold", Z);
        fetch(16'hF000, "post_rst");
        cyc("post_rst_ex1", ex(DONE, 8'h00, 4'd0, 3'd0, 2'd0));
        run = 1'b0;
        for (int i = 0; i < 10 && exps.size() > 0; i++) @(posedge clock);
        #1;
        if (exps.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exps.size());
        end
        if (checks != pushed) begin
            errors++;
            $display("FAIL monitor_count: got %0d expected %0d", checks, pushed);
        end
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
